// File: rtl/regfile_pkg.sv
// Shared constants and write-port arbitration for the multiport register file.
package regfile_pkg;

    localparam int defaultWidth     = 32;
    localparam int defaultAddrWidth = 5;
    localparam int maxRead          = 8;
    localparam int maxWrite         = 4;

    typedef logic [maxWrite-1:0] portMaskT;

    // One-hot mask of the port whose data lands; the highest-indexed hit wins.
    function automatic portMaskT resolveWinner(input portMaskT hitMask);
        portMaskT winMask;
        winMask = '0;
        for (int j = 0; j < maxWrite; j++) begin
            if (hitMask[j]) begin
                winMask = portMaskT'(1) << j;
            end
        end
        return winMask;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback-side bus of the multiport register file (reads, writes, busy claims).
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int width     = defaultWidth,
    parameter int addrWidth = defaultAddrWidth,
    parameter int nRead     = 2,
    parameter int nWrite    = 1
);

    logic [nRead*addrWidth-1:0]  readAddr;
    logic [nRead*width-1:0]      dOut;
    logic [nRead-1:0]            readBusy;
    logic [nWrite*addrWidth-1:0] writeAddr;
    logic [nWrite*width-1:0]     dIn;
    logic [nWrite-1:0]           we;
    logic [addrWidth-1:0]        claimAddr;
    logic                        claim;

    modport master (
        output readAddr, writeAddr, dIn, we, claimAddr, claim,
        input  dOut, readBusy
    );

    modport slave (
        input  readAddr, writeAddr, dIn, we, claimAddr, claim,
        output dOut, readBusy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by a claim, cleared by a completing write, looked up per read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int addrWidth = defaultAddrWidth,
    parameter int depth     = 2 ** addrWidth,
    parameter int nRead     = 2,
    parameter int nWrite    = 1,
    parameter int bypass    = 1,
    parameter int readReg   = 0
) (
    input  logic                        clk,
    input  logic                        nReset,
    input  logic [nWrite*addrWidth-1:0] writeAddr,
    input  logic [nWrite-1:0]           we,
    input  logic [addrWidth-1:0]        claimAddr,
    input  logic                        claim,
    input  logic [nRead*addrWidth-1:0]  readAddr,
    output logic [nRead-1:0]            readBusy
);

    logic [depth-1:0] busyReg;
    logic [depth-1:0] busyNext;
    logic [depth-1:0] clearHit;
    logic [nRead-1:0] busyLookup;

    genvar gi;
    for (gi = 0; gi < depth; gi++) begin : g_clear
        portMaskT hitMask;
        portMaskT winMask;
        always_comb begin
            hitMask = '0;
            for (int j = 0; j < nWrite; j++) begin
                hitMask[j] = we[j] && (writeAddr[j*addrWidth +: addrWidth] == addrWidth'(gi));
            end
        end
        assign winMask      = resolveWinner(hitMask);
        assign clearHit[gi] = |winMask;
    end

    // The claim is applied after the clears so a new producer supersedes a completing one.
    always_comb begin
        busyNext = busyReg & ~clearHit;
        if (claim && (claimAddr != '0) && (32'(claimAddr) < depth)) begin
            busyNext[claimAddr] = 1'b1;
        end
        busyNext[0] = 1'b0;
        if (!nReset) begin
            busyNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            busyReg <= '0;
        end else begin
            busyReg <= busyNext;
        end
    end

    for (gi = 0; gi < nRead; gi++) begin : g_read
        logic [addrWidth-1:0] addr;
        logic                 lookup;
        assign addr = readAddr[gi*addrWidth +: addrWidth];
        always_comb begin
            lookup = 1'b0;
            if (32'(addr) < depth) begin
                lookup = (bypass != 0) ? busyNext[addr] : busyReg[addr];
            end
        end
        assign busyLookup[gi] = lookup;
    end

    if (readReg != 0) begin : g_regOut
        logic [nRead-1:0] readBusyReg;
        always_ff @(posedge clk) begin
            if (!nReset) begin
                readBusyReg <= '0;
            end else begin
                readBusyReg <= busyLookup;
            end
        end
        assign readBusy = readBusyReg;
    end else begin : g_combOut
        assign readBusy = busyLookup;
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, multi-write register file with optional forwarding, registered reads
// and a busy scoreboard for multicycle / out-of-order writeback.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int width     = defaultWidth,
    parameter int addrWidth = defaultAddrWidth,
    parameter int depth     = 2 ** addrWidth,
    parameter int nRead     = 2,
    parameter int nWrite    = 1,
    parameter int bypass    = 1,
    parameter int readReg   = 0
) (
    input logic                clk,
    input logic                nReset,
    regfile_multiport_if.slave bus
);

    if (width < 1) begin : g_badWidth
        $error("regfile_multiport: width %0d must be at least 1", width);
    end
    if (addrWidth < 1 || addrWidth > 31) begin : g_badAddrWidth
        $error("regfile_multiport: addrWidth %0d out of range 1..31", addrWidth);
    end
    if (depth < 1 || depth > 2 ** addrWidth) begin : g_badDepth
        $error("regfile_multiport: depth %0d out of range 1..%0d", depth, 2 ** addrWidth);
    end
    if (nRead < 1 || nRead > maxRead) begin : g_badRead
        $error("regfile_multiport: nRead %0d out of range 1..%0d", nRead, maxRead);
    end
    if (nWrite < 1 || nWrite > maxWrite) begin : g_badWrite
        $error("regfile_multiport: nWrite %0d out of range 1..%0d", nWrite, maxWrite);
    end
    if (bypass < 0 || bypass > 1) begin : g_badBypass
        $error("regfile_multiport: bypass %0d must be 0 or 1", bypass);
    end
    if (readReg < 0 || readReg > 1) begin : g_badReadReg
        $error("regfile_multiport: readReg %0d must be 0 or 1", readReg);
    end

    logic [nWrite-1:0]      weLive;
    portMaskT               weArr;
    logic [addrWidth-1:0]   writeAddrArr [maxWrite];
    logic [width-1:0]       dInArr [maxWrite];
    logic [width-1:0]       regs [depth];
    portMaskT               regWin [depth];
    logic [nRead*width-1:0] readLookup;

    // A write presented in a reset cycle neither lands nor forwards.
    assign weLive = bus.we & {nWrite{nReset}};

    genvar gi;
    for (gi = 0; gi < maxWrite; gi++) begin : g_wport
        if (gi < nWrite) begin : g_used
            assign weArr[gi]        = weLive[gi];
            assign writeAddrArr[gi] = bus.writeAddr[gi*addrWidth +: addrWidth];
            assign dInArr[gi]       = bus.dIn[gi*width +: width];
        end else begin : g_pad
            assign weArr[gi]        = 1'b0;
            assign writeAddrArr[gi] = '0;
            assign dInArr[gi]       = '0;
        end
    end

    for (gi = 0; gi < depth; gi++) begin : g_reg
        portMaskT hitMask;
        always_comb begin
            hitMask = '0;
            for (int j = 0; j < maxWrite; j++) begin
                hitMask[j] = weArr[j] && (gi != 0) && (writeAddrArr[j] == addrWidth'(gi));
            end
        end
        assign regWin[gi] = resolveWinner(hitMask);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            for (int r = 0; r < depth; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < depth; r++) begin
                for (int j = 0; j < maxWrite; j++) begin
                    if (regWin[r][j]) begin
                        regs[r] <= dInArr[j];
                    end
                end
            end
        end
    end

    for (gi = 0; gi < nRead; gi++) begin : g_read
        logic [addrWidth-1:0] addr;
        logic                 addrLive;
        portMaskT             hitMask;
        portMaskT             winMask;
        logic [width-1:0]     lookupData;

        assign addr     = bus.readAddr[gi*addrWidth +: addrWidth];
        assign addrLive = (addr != '0) && (32'(addr) < depth);

        always_comb begin
            hitMask = '0;
            for (int j = 0; j < maxWrite; j++) begin
                hitMask[j] = weArr[j] && (writeAddrArr[j] == addr);
            end
        end
        assign winMask = resolveWinner(hitMask);

        always_comb begin
            lookupData = regs[addr];
            if (bypass != 0) begin
                for (int j = 0; j < maxWrite; j++) begin
                    if (winMask[j]) begin
                        lookupData = dInArr[j];
                    end
                end
            end
            if (!addrLive) begin
                lookupData = '0;
            end
        end
        assign readLookup[gi*width +: width] = lookupData;
    end

    // Registering the forwarded lookup gives post-edge data; the plain lookup gives pre-edge data.
    if (readReg != 0) begin : g_regOut
        logic [nRead*width-1:0] dOutReg;
        always_ff @(posedge clk) begin
            if (!nReset) begin
                dOutReg <= '0;
            end else begin
                dOutReg <= readLookup;
            end
        end
        assign bus.dOut = dOutReg;
    end else begin : g_combOut
        assign bus.dOut = readLookup;
    end

    regfile_scoreboard #(
        .addrWidth (addrWidth),
        .depth     (depth),
        .nRead     (nRead),
        .nWrite    (nWrite),
        .bypass    (bypass),
        .readReg   (readReg)
    ) scoreboard (
        .clk       (clk),
        .nReset    (nReset),
        .writeAddr (bus.writeAddr),
        .we        (weLive),
        .claimAddr (bus.claimAddr),
        .claim     (bus.claim),
        .readAddr  (bus.readAddr),
        .readBusy  (bus.readBusy)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Four register files (combinational/registered read x bypass on/off) share one stimulus
// stream and are scored against an array model of registers and busy bits.
module tb_regfile_multiport;

    localparam int W    = 32;
    localparam int AW   = 5;
    localparam int NR   = 3;
    localparam int NW   = 2;
    localparam int NCFG = 4;

    logic             clk;
    logic             nReset;
    logic [NR*AW-1:0] readAddr;
    logic [NW*AW-1:0] writeAddr;
    logic [NW*W-1:0]  dIn;
    logic [NW-1:0]    we;
    logic [AW-1:0]    claimAddr;
    logic             claim;

    logic [NR*W-1:0]  dOutAll [NCFG];
    logic [NR-1:0]    busyAll [NCFG];

    // cfg 0: comb+bypass, 1: comb, 2: registered+bypass, 3: registered
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        regfile_multiport_if #(.width(W), .addrWidth(AW), .nRead(NR), .nWrite(NW)) bus ();
        assign bus.readAddr  = readAddr;
        assign bus.writeAddr = writeAddr;
        assign bus.dIn       = dIn;
        assign bus.we        = we;
        assign bus.claimAddr = claimAddr;
        assign bus.claim     = claim;
        assign dOutAll[gi]   = bus.dOut;
        assign busyAll[gi]   = bus.readBusy;
        regfile_multiport #(
            .width(W), .addrWidth(AW), .depth(32), .nRead(NR), .nWrite(NW),
            .bypass((gi % 2 == 0) ? 1 : 0), .readReg(gi / 2)
        ) dut (
            .clk    (clk),
            .nReset (nReset),
            .bus    (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     due;
        logic            chk;
        logic [NR*W-1:0] dataA;
        logic [NR-1:0]   busyA;
        logic [NR*W-1:0] dataB;
        logic [NR-1:0]   busyB;
    } expT;

    expT combQ[$];
    expT regQ[$];

    logic [W-1:0] mem [32];
    logic [31:0]  busyBits;
    int drvCyc = 0;
    int monCyc = 0;
    int nVec   = 0;
    int nMis   = 0;

    task automatic cmp(input string what, input int cfg, input logic [NR*W-1:0] got,
                       input logic [NR*W-1:0] want);
        nVec++;
        if (got !== want) begin
            nMis++;
            $display("FAIL %s cfg%0d cycle %0d: got %h want %h", what, cfg, monCyc, got, want);
        end
    endtask

    // Drive one cycle and predict: A = state after this edge, B = state before it.
    task automatic applyCycle(input logic rstN, input logic [NR*AW-1:0] ra,
                              input logic [NW*AW-1:0] wa, input logic [NW*W-1:0] wd,
                              input logic [NW-1:0] wen, input logic [AW-1:0] ca, input logic cl);
        logic [W-1:0] nextMem [32];
        logic [31:0]  nextBusy;
        expT ce;
        expT re;
        @(negedge clk);
        nReset = rstN; readAddr = ra; writeAddr = wa; dIn = wd; we = wen;
        claimAddr = ca; claim = cl;
        nextMem  = mem;
        nextBusy = busyBits;
        if (!rstN) begin
            for (int r = 0; r < 32; r++) nextMem[r] = '0;
            nextBusy = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                int a;
                a = int'(wa[j*AW +: AW]);
                if (wen[j] && a != 0) begin
                    nextMem[a]  = wd[j*W +: W];
                    nextBusy[a] = 1'b0;
                end
            end
            if (cl && ca != 0) nextBusy[ca] = 1'b1;
        end
        ce.due = 32'(drvCyc);
        ce.chk = rstN;
        for (int i = 0; i < NR; i++) begin
            int a;
            a = int'(ra[i*AW +: AW]);
            ce.dataA[i*W +: W] = nextMem[a];
            ce.busyA[i]        = nextBusy[a];
            ce.dataB[i*W +: W] = mem[a];
            ce.busyB[i]        = busyBits[a];
        end
        re     = ce;
        re.due = 32'(drvCyc + 1);
        re.chk = 1'b1;
        if (!rstN) begin
            re.dataB = '0;
            re.busyB = '0;
        end
        combQ.push_back(ce);
        regQ.push_back(re);
        mem      = nextMem;
        busyBits = nextBusy;
        drvCyc++;
    endtask

    task automatic readOnly(input logic [NR*AW-1:0] ra);
        applyCycle(1'b1, ra, '0, '0, 2'b00, '0, 1'b0);
    endtask

    function automatic logic [AW-1:0] pickAddr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin : monitor
        expT e;
        forever begin
            @(negedge clk);
            #2;
            if (combQ.size() > 0 && combQ[0].due == 32'(monCyc)) begin
                e = combQ.pop_front();
                if (e.chk) begin
                    cmp("dOut", 0, dOutAll[0], e.dataA);
                    cmp("readBusy", 0, (NR*W)'(busyAll[0]), (NR*W)'(e.busyA));
                    cmp("dOut", 1, dOutAll[1], e.dataB);
                    cmp("readBusy", 1, (NR*W)'(busyAll[1]), (NR*W)'(e.busyB));
                end
            end
            if (regQ.size() > 0 && regQ[0].due == 32'(monCyc)) begin
                e = regQ.pop_front();
                cmp("dOut", 2, dOutAll[2], e.dataA);
                cmp("readBusy", 2, (NR*W)'(busyAll[2]), (NR*W)'(e.busyA));
                cmp("dOut", 3, dOutAll[3], e.dataB);
                cmp("readBusy", 3, (NR*W)'(busyAll[3]), (NR*W)'(e.busyB));
            end
            monCyc++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin : driver
        nReset = 1'b0; readAddr = '0; writeAddr = '0; dIn = '0; we = '0;
        claimAddr = '0; claim = 1'b0;
        for (int r = 0; r < 32; r++) mem[r] = '0;
        busyBits = '0;

        applyCycle(1'b0, '0, '0, '0, 2'b00, '0, 1'b0);
        applyCycle(1'b0, '0, '0, '0, 2'b00, '0, 1'b0);

        // r5 write then read on every port; writes to r0 are dropped
        applyCycle(1'b1, {3{5'd5}}, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 2'b01, '0, 1'b0);
        readOnly({3{5'd5}});
        applyCycle(1'b1, {3{5'd0}}, {5'd0, 5'd0}, {32'h12345678, 32'h9}, 2'b11, '0, 1'b0);
        readOnly({5'd5, 5'd0, 5'd0});

        // both ports hit r7: port 1 wins
        applyCycle(1'b1, {3{5'd7}}, {5'd7, 5'd7}, {32'h22, 32'h11}, 2'b11, '0, 1'b0);
        readOnly({3{5'd7}});

        // r3 old/new value in the same cycle
        applyCycle(1'b1, {3{5'd3}}, {5'd0, 5'd3}, {32'd0, 32'h1}, 2'b01, '0, 1'b0);
        applyCycle(1'b1, {3{5'd3}}, {5'd0, 5'd3}, {32'd0, 32'h2}, 2'b01, '0, 1'b0);
        readOnly({3{5'd3}});

        // r9 registered-read latency
        readOnly({3{5'd9}});
        applyCycle(1'b1, {3{5'd9}}, {5'd9, 5'd0}, {32'hA5, 32'h0}, 2'b10, '0, 1'b0);
        readOnly({3{5'd9}});

        // scoreboard: claim, release, claim+write, claim of r0
        applyCycle(1'b1, {3{5'd4}}, '0, '0, 2'b00, 5'd4, 1'b1);
        readOnly({3{5'd4}});
        applyCycle(1'b1, {3{5'd4}}, {5'd4, 5'd0}, {32'h44, 32'h0}, 2'b10, '0, 1'b0);
        readOnly({3{5'd4}});
        applyCycle(1'b1, {3{5'd4}}, {5'd0, 5'd4}, {32'h0, 32'h45}, 2'b01, 5'd4, 1'b1);
        readOnly({3{5'd4}});
        applyCycle(1'b1, {3{5'd0}}, '0, '0, 2'b00, 5'd0, 1'b1);
        readOnly({3{5'd0}});

        // fill every register and busy bit, then reset with a write pending
        for (int r = 1; r < 32; r += 2) begin
            applyCycle(1'b1, {AW'(r + 1), AW'(r), AW'(r)}, {AW'(r + 1), AW'(r)},
                       {32'(r + 1) * 32'h01010101, 32'(r) * 32'h01010101}, 2'b11, AW'(r), 1'b1);
        end
        for (int r = 2; r < 32; r += 2) begin
            applyCycle(1'b1, {AW'(r + 1), AW'(r), AW'(r - 1)}, '0, '0, 2'b00, AW'(r), 1'b1);
        end
        applyCycle(1'b0, {3{5'd10}}, {5'd10, 5'd11}, {32'hFFFF, 32'hEEEE}, 2'b11, 5'd12, 1'b1);
        for (int r = 0; r < 32; r += 3) begin
            readOnly({AW'(r + 2), AW'(r + 1), AW'(r)});
        end

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [NR*AW-1:0] ra;
            logic [NW*AW-1:0] wa;
            logic [NW*W-1:0]  wd;
            for (int i = 0; i < NR; i++) ra[i*AW +: AW] = pickAddr();
            for (int j = 0; j < NW; j++) begin
                wa[j*AW +: AW] = pickAddr();
                wd[j*W +: W]   = $urandom;
            end
            applyCycle(($urandom_range(0, 99) != 0), ra, wa, wd, NW'($urandom),
                       pickAddr(), ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        #5;
        nVec++;
        if (combQ.size() != 0 || regQ.size() != 0) begin
            nMis++;
            $display("FAIL drain: got %0d comb and %0d registered expectations left, want 0 and 0",
                     combQ.size(), regQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, two-read MIPS register file.
- Configurable read-port count, write-port count, optional registered reads and write-to-read forwarding, plus a per-register busy scoreboard for multicycle and out-of-order writeback.
- Sits between decode (reads and claims) and writeback (writes and busy release).
- Register 0 reads as 0, is never written and is never busy.

Parameters:
- width, 32: data bits per register.
- addrWidth, 5: register address bits.
- depth, 2**addrWidth: number of registers.
- nRead, 2: read ports (1..8).
- nWrite, 1: write ports (1..4).
- bypass, 1: 1 = same-cycle write data forwarded to reads; 0 = reads return the pre-write value.
- readReg, 0: 0 = combinational read; 1 = registered read with 1-cycle latency.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- nReset  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- readAddr  in  nRead*addrWidth  read port i address is slice [i*addrWidth +: addrWidth].
- dOut  out  nRead*width  read port i data is slice [i*width +: width].
- readBusy  out  nRead  busy bit of the register addressed by read port i (same latency as dOut).
- writeAddr  in  nWrite*addrWidth  write port j address.
- dIn  in  nWrite*width  write port j data.
- we  in  nWrite  write enable per write port.
- claimAddr  in  addrWidth  register to mark busy (destination of an issued multicycle op).
- claim  in  1  claim strobe.

Behaviour:
- Reset (nReset=0 at an edge):
  - All registers, all busy bits and (if readReg=1) all dOut/readBusy output registers clear to 0.
  - Writes and claims in that cycle are ignored.
  - In-flight registered reads are discarded; the first cycle after reset presents 0.
- Writes:
  - On an edge with we[j]=1 and writeAddr[j]!=0, the register takes dIn[j].
  - writeAddr 0 is ignored.
  - Same-address conflict between write ports: the highest-indexed port wins; the others have no effect.
- Reads, readReg=0:
  - dOut[i] is combinational.
  - Address 0 always returns 0.
  - bypass=1: if any active write targets readAddr[i] (nonzero) in the same cycle, dOut[i] = dIn of the winning port; otherwise the stored value.
  - bypass=0: always the stored value.
- Reads, readReg=1:
  - readAddr sampled at edge t; dOut valid after edge t (1-cycle latency).
  - bypass=1: reflects writes committed at edge t.
  - bypass=0: reflects the state before edge t.
- Scoreboard:
  - claim=1 with claimAddr!=0 sets busy[claimAddr] at the edge.
  - An active write to address a clears busy[a] at the edge.
  - Simultaneous claim and write to the same address: claim wins, busy stays 1 (a new producer supersedes the completing one).
  - claimAddr 0 is ignored.
  - readBusy[i] follows the same combinational/registered and bypass rules as dOut, using the post-edge busy value when bypass=1.
- Width and parameter rules:
  - No arithmetic; addresses at or above depth (depth < 2**addrWidth) read 0 and writes to them are ignored.
  - Parameter values outside the stated ranges stop elaboration with $error.

Decomposition:
- Shared package regfile_pkg: default width/addrWidth constants, the maximum port counts, and the helper function that resolves the winning write port for an address (used by both the storage and the scoreboard).
- One sub-module, regfile_scoreboard: depth-bit busy vector with claim/clear logic and per-port busy lookup, sharing the same bypass/readReg parameters.

Test Plan:
- Reset, then with readReg=0, bypass=1: write 0xDEADBEEF to r5 via port 0, read r5 on both ports next cycle -> 0xDEADBEEF on both; write to r0 -> r0 still reads 0.
- nWrite=2: both ports write r7 in one cycle (0x11, 0x22) -> r7 = 0x22; the same-cycle forwarded read also shows 0x22.
- bypass=0, readReg=0: read and write r3 (old 0x1, new 0x2) in the same cycle -> dOut 0x1 that cycle, 0x2 the next.
- readReg=1, bypass=1: present addr r9 at edge t together with a write of 0xA5 to r9 -> dOut = 0xA5 after edge t; dOut = 0 in the cycle before t.
- Scoreboard: claim r4 -> readBusy=1; a later write to r4 -> readBusy=0; claim and write r4 in the same cycle -> readBusy stays 1; claim r0 -> readBusy for r0 stays 0.
- Reset mid-operation: fill r1..r31 and busy bits, assert nReset=0 for one edge with we=1 -> all reads 0 and all busy bits 0, and the write is dropped.
